// File: rtl/zap_wb_slave_mem_pkg.sv
// zap_wb_slave_mem_pkg
//   Shared constants for the Wishbone responder and the core-side adapter.
//   The CTI encodings and the responder FSM state enum live here.
package zap_wb_slave_mem_pkg;

   // Wishbone B3 cycle type identifiers
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_BURST   = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LATENCY = 2'd1,
      ST_ACTIVE  = 2'd2
   } state_t;

endpackage

// File: rtl/zap_wb_slave_mem_if.sv
// zap_wb_slave_mem_if
//   Wishbone B3 bus bundle between a master and the memory responder.
//   master modport drives cyc/stb/we/sel/cti/adr/dat_w and samples dat_r/ack;
//   slave modport is the mirror image.
interface zap_wb_slave_mem_if;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [3:0]  wb_sel;
   logic [2:0]  wb_cti;
   logic [31:0] wb_adr;
   logic [31:0] wb_dat_w;
   logic [31:0] wb_dat_r;
   logic        wb_ack;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_adr, wb_dat_w,
      input  wb_dat_r, wb_ack
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_adr, wb_dat_w,
      output wb_dat_r, wb_ack
   );
endinterface

// File: rtl/zap_wb_ram_bytewise.sv
// zap_wb_ram_bytewise
//   Word RAM with four byte-lane write enables, one write and one
//   synchronous read per cycle on independent addresses.
//   Ports:
//     i_clk, i_reset_n : clock, async active-low reset (read register only)
//     i_we, i_wadr, i_sel, i_wdat : write port, i_sel[n] enables byte n
//     i_re, i_radr     : read enable / address
//     o_rdat           : registered read data, holds when i_re is low
//   Array contents are never reset.
module zap_wb_ram_bytewise #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_wadr,
   input  logic [3:0]    i_sel,
   input  logic [31:0]   i_wdat,
   input  logic          i_re,
   input  logic [AW-1:0] i_radr,
   output logic [31:0]   o_rdat
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_sel[b]) mem[i_wadr][8*b +: 8] <= i_wdat[8*b +: 8];
         end
      end
   end

   // Read-before-write on a shared address: old data is returned.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)  o_rdat <= '0;
      else if (i_re)   o_rdat <= mem[i_radr];
   end

endmodule

// File: rtl/zap_wb_slave_mem.sv
// zap_wb_slave_mem
//   Wishbone B3 responder backed by a byte-enabled word RAM. Serves classic
//   cycles and linear incrementing bursts (CTI 010 / 111) with a registered
//   ACK after a programmable first-beat latency.
//   Ports:
//     i_clk      : clock
//     i_reset_n  : async active-low reset
//     wb         : Wishbone slave bundle (cyc/stb/we/sel/cti/adr/dat_w in,
//                  dat_r/ack out)
//     o_adr_err  : sticky flag, burst beat address differed from the
//                  internally tracked address
module zap_wb_slave_mem
   import zap_wb_slave_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int FIRST_LAT   = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   zap_wb_slave_mem_if.slave    wb,
   output logic                 o_adr_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   // Counter only needs to hold FIRST_LAT-1.
   localparam int CW = (FIRST_LAT > 1) ? $clog2(FIRST_LAT) : 1;

   if (FIRST_LAT < 1) begin : g_bad_lat
      $error("zap_wb_slave_mem: FIRST_LAT must be >= 1");
   end
   if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("zap_wb_slave_mem: DEPTH_WORDS must be a power of two >= 2");
   end

   state_t          state_q, state_d;
   logic [AW-1:0]   iadr_q, iadr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            req;
   logic [AW-1:0]   bus_idx;
   logic            ram_we, ram_re, err_set;
   logic [AW-1:0]   ram_radr;
   logic [31:0]     ram_rdat;
   logic            unused_adr_bits;

   assign req     = wb.wb_cyc & wb.wb_stb;
   // Upper address bits alias onto the array.
   assign bus_idx = wb.wb_adr[AW+1:2];
   assign unused_adr_bits = ^{wb.wb_adr[31:AW+2], wb.wb_adr[1:0]};

   assign wb.wb_ack   = (state_q == ST_ACTIVE);
   assign wb.wb_dat_r = ram_rdat;

   always_comb begin
      state_d  = state_q;
      iadr_d   = iadr_q;
      cnt_d    = cnt_q;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_radr = iadr_q;
      err_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               iadr_d = bus_idx;
               if (FIRST_LAT == 1) begin
                  state_d  = ST_ACTIVE;
                  ram_re   = 1'b1;
                  ram_radr = bus_idx;
               end else begin
                  state_d = ST_LATENCY;
                  cnt_d   = CW'(FIRST_LAT - 1);
               end
            end
         end
         ST_LATENCY: begin
            if (!req) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = ST_ACTIVE;
                  ram_re  = 1'b1;
               end
            end
         end
         ST_ACTIVE: begin
            // A dropped cycle commits nothing and ends the access.
            if (req && wb.wb_we)       ram_we  = 1'b1;
            if (req && bus_idx != iadr_q) err_set = 1'b1;
            // Prefetch the next word so the following beat ACKs back-to-back;
            // the write in this cycle targets a different word.
            if (req && wb.wb_cti == CTI_BURST) begin
               iadr_d   = iadr_q + AW'(1);
               ram_re   = 1'b1;
               ram_radr = iadr_q + AW'(1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         iadr_q    <= '0;
         cnt_q     <= '0;
         o_adr_err <= 1'b0;
      end else begin
         state_q <= state_d;
         iadr_q  <= iadr_d;
         cnt_q   <= cnt_d;
         if (err_set) o_adr_err <= 1'b1;
      end
   end

   zap_wb_ram_bytewise #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_ram (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_we      (ram_we),
      .i_wadr    (bus_idx),
      .i_sel     (wb.wb_sel),
      .i_wdat    (wb.wb_dat_w),
      .i_re      (ram_re),
      .i_radr    (ram_radr),
      .o_rdat    (ram_rdat)
   );

endmodule

// File: tb/tb_zap_wb_slave_mem.sv
// tb_zap_wb_slave_mem
//   Three responders with different geometry:
//     0: DEPTH 1024, FIRST_LAT 1
//     1: DEPTH 16,   FIRST_LAT 3
//     2: DEPTH 1024, FIRST_LAT 4
module tb_zap_wb_slave_mem;
   import zap_wb_slave_mem_pkg::*;

   logic i_clk = 1'b0;
   logic i_reset_n = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic        cyc  [3];
   logic        stb  [3];
   logic        we   [3];
   logic [3:0]  sel  [3];
   logic [2:0]  cti  [3];
   logic [31:0] adr  [3];
   logic [31:0] wdat [3];
   logic        ack  [3];
   logic [31:0] rdat [3];
   logic        aerr [3];

   logic [31:0] bres [8];
   int          blat;
   int          backs;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      zap_wb_slave_mem_if wbi ();
      assign wbi.wb_cyc   = cyc[g];
      assign wbi.wb_stb   = stb[g];
      assign wbi.wb_we    = we[g];
      assign wbi.wb_sel   = sel[g];
      assign wbi.wb_cti   = cti[g];
      assign wbi.wb_adr   = adr[g];
      assign wbi.wb_dat_w = wdat[g];
      assign ack[g]       = wbi.wb_ack;
      assign rdat[g]      = wbi.wb_dat_r;
      zap_wb_slave_mem #(
         .DEPTH_WORDS ((g == 1) ? 16 : 1024),
         .FIRST_LAT   ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .wb        (wbi),
         .o_adr_err (aerr[g])
      );
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_bus(input int d);
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0;
      cti[d] = CTI_CLASSIC; adr[d] = '0; wdat[d] = '0;
   endtask

   // One classic transfer; lat = edges from presenting the request to ACK.
   task automatic classic(input int d, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s;
      cti[d] = CTI_CLASSIC; adr[d] = a; wdat[d] = wd;
      lat = 0;
      do begin step(); lat++; end while (!ack[d] && lat < 20);
      rd = rdat[d];
      step();
      idle_bus(d);
   endtask

   // n-beat burst; skip adds one extra word to every beat after the first.
   task automatic burst(input int d, input logic w, input logic [31:0] base,
                        input int n, input logic skip);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = 4'hF;
      cti[d] = (n > 1) ? CTI_BURST : CTI_EOB;
      adr[d] = base; wdat[d] = 32'hCAFE0000;
      blat = 0;
      do begin step(); blat++; end while (!ack[d] && blat < 20);
      backs = 0;
      for (int i = 0; i < n; i++) begin
         if (!ack[d]) break;
         backs++;
         bres[i] = rdat[d];
         step();
         if (i < n - 1) begin
            adr[d]  = base + 32'(4 * (i + 1)) + (skip ? 32'd4 : 32'd0);
            cti[d]  = (i + 1 == n - 1) ? CTI_EOB : CTI_BURST;
            wdat[d] = 32'hCAFE0000 + 32'(i + 1);
         end
      end
      idle_bus(d);
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) idle_bus(d);
      i_reset_n = 1'b0;
      step();
      for (int d = 0; d < 3; d++) begin
         n_chk++;
         if (ack[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b want 0", d, ack[d]); end
         n_chk++;
         if (rdat[d] !== 32'h0) begin n_fail++; $display("FAIL reset_dat[%0d]: got %h want 0", d, rdat[d]); end
         n_chk++;
         if (aerr[d] !== 1'b0) begin n_fail++; $display("FAIL reset_aerr[%0d]: got %b want 0", d, aerr[d]); end
      end
      i_reset_n = 1'b1;
      step();
   endtask

   task automatic test_classic();
      logic [31:0] rd;
      int lat;
      classic(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, rd, lat);
      n_chk++;
      if (lat !== 1) begin n_fail++; $display("FAIL classic_wr_lat: got %0d want 1", lat); end
      n_chk++;
      if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL classic_wr_ack_drop: got %b want 0", ack[0]); end
      classic(0, 1'b0, 32'h100, 4'hF, 32'h0, rd, lat);
      n_chk++;
      if (lat !== 1) begin n_fail++; $display("FAIL classic_rd_lat: got %0d want 1", lat); end
      n_chk++;
      if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL classic_rd_dat: got %h want deadbeef", rd); end
      repeat (3) step();
      n_chk++;
      if (rdat[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL classic_dat_hold: got %h want deadbeef", rdat[0]); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd;
      int lat;
      classic(0, 1'b1, 32'h104, 4'hF, 32'h11223344, rd, lat);
      classic(0, 1'b1, 32'h104, 4'b0100, 32'hAABBCCDD, rd, lat);
      classic(0, 1'b0, 32'h104, 4'hF, 32'h0, rd, lat);
      n_chk++;
      if (rd !== 32'h11BB3344) begin n_fail++; $display("FAIL byte_lanes: got %h want 11bb3344", rd); end
   endtask

   task automatic test_burst_read();
      logic [31:0] rd;
      int lat;
      for (int i = 0; i < 4; i++)
         classic(1, 1'b1, 32'h200 + 32'(4 * i), 4'hF, 32'h10000000 + 32'(i), rd, lat);
      n_chk++;
      if (lat !== 3) begin n_fail++; $display("FAIL lat3_classic: got %0d want 3", lat); end
      burst(1, 1'b0, 32'h200, 4, 1'b0);
      n_chk++;
      if (blat !== 3) begin n_fail++; $display("FAIL burst_first_lat: got %0d want 3", blat); end
      n_chk++;
      if (backs !== 4) begin n_fail++; $display("FAIL burst_acks: got %0d want 4", backs); end
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (bres[i] !== 32'h10000000 + 32'(i)) begin
            n_fail++; $display("FAIL burst_dat[%0d]: got %h want %h", i, bres[i], 32'h10000000 + 32'(i));
         end
      end
      n_chk++;
      if (ack[1] !== 1'b0) begin n_fail++; $display("FAIL burst_idle_after: got %b want 0", ack[1]); end
      n_chk++;
      if (aerr[1] !== 1'b0) begin n_fail++; $display("FAIL burst_aerr: got %b want 0", aerr[1]); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      logic [31:0] a;
      int lat;
      // word 14 of a 16-word array
      burst(1, 1'b1, 32'h38, 4, 1'b0);
      n_chk++;
      if (backs !== 4) begin n_fail++; $display("FAIL wrap_acks: got %0d want 4", backs); end
      n_chk++;
      if (aerr[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_aerr: got %b want 0", aerr[1]); end
      for (int i = 0; i < 4; i++) begin
         a = (i < 2) ? 32'h38 + 32'(4 * i) : 32'(4 * (i - 2));
         classic(1, 1'b0, a, 4'hF, 32'h0, rd, lat);
         n_chk++;
         if (rd !== 32'hCAFE0000 + 32'(i)) begin
            n_fail++; $display("FAIL wrap_word[%0d]: got %h want %h", i, rd, 32'hCAFE0000 + 32'(i));
         end
      end
      // word 2 lies beyond the wrapped burst and keeps its earlier value
      classic(1, 1'b0, 32'h08, 4'hF, 32'h0, rd, lat);
      n_chk++;
      if (rd !== 32'h10000002) begin n_fail++; $display("FAIL wrap_overrun: got %h want 10000002", rd); end
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      int lat;
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF;
      cti[2] = CTI_CLASSIC; adr[2] = 32'h40;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++;
         if (ack[2] !== 1'b0) begin n_fail++; $display("FAIL abort_ack_pending[%0d]: got %b want 0", i, ack[2]); end
      end
      stb[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_chk++;
         if (ack[2] !== 1'b0) begin n_fail++; $display("FAIL abort_ack_after[%0d]: got %b want 0", i, ack[2]); end
      end
      idle_bus(2);
      classic(2, 1'b1, 32'h40, 4'hF, 32'h55AA33CC, rd, lat);
      n_chk++;
      if (lat !== 4) begin n_fail++; $display("FAIL abort_next_wr_lat: got %0d want 4", lat); end
      classic(2, 1'b0, 32'h40, 4'hF, 32'h0, rd, lat);
      n_chk++;
      if (lat !== 4) begin n_fail++; $display("FAIL abort_next_rd_lat: got %0d want 4", lat); end
      n_chk++;
      if (rd !== 32'h55AA33CC) begin n_fail++; $display("FAIL abort_next_rd_dat: got %h want 55aa33cc", rd); end
   endtask

   task automatic test_adr_err();
      n_chk++;
      if (aerr[0] !== 1'b0) begin n_fail++; $display("FAIL adr_err_pre: got %b want 0", aerr[0]); end
      burst(0, 1'b0, 32'h300, 2, 1'b1);
      n_chk++;
      if (backs !== 2) begin n_fail++; $display("FAIL adr_err_acks: got %0d want 2", backs); end
      n_chk++;
      if (aerr[0] !== 1'b1) begin n_fail++; $display("FAIL adr_err_set: got %b want 1", aerr[0]); end
      repeat (3) step();
      n_chk++;
      if (aerr[0] !== 1'b1) begin n_fail++; $display("FAIL adr_err_sticky: got %b want 1", aerr[0]); end
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] rd;
      int lat;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF;
      cti[0] = CTI_BURST; adr[0] = 32'h100;
      lat = 0;
      do begin step(); lat++; end while (!ack[0] && lat < 20);
      step();
      adr[0] = 32'h104;
      n_chk++;
      if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL rmb_beat2_ack: got %b want 1", ack[0]); end
      n_chk++;
      if (rdat[0] !== 32'h11BB3344) begin n_fail++; $display("FAIL rmb_beat2_dat: got %h want 11bb3344", rdat[0]); end
      i_reset_n = 1'b0;
      #1;
      n_chk++;
      if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL rmb_ack: got %b want 0", ack[0]); end
      n_chk++;
      if (rdat[0] !== 32'h0) begin n_fail++; $display("FAIL rmb_dat: got %h want 0", rdat[0]); end
      n_chk++;
      if (aerr[0] !== 1'b0) begin n_fail++; $display("FAIL rmb_aerr: got %b want 0", aerr[0]); end
      idle_bus(0);
      step();
      i_reset_n = 1'b1;
      step();
      classic(0, 1'b0, 32'h100, 4'hF, 32'h0, rd, lat);
      n_chk++;
      if (lat !== 1) begin n_fail++; $display("FAIL rmb_post_lat: got %0d want 1", lat); end
      n_chk++;
      if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rmb_ram_kept: got %h want deadbeef", rd); end
   endtask

   initial begin
      test_reset();
      test_classic();
      test_byte_lanes();
      test_burst_read();
      test_wrap();
      test_abort();
      test_adr_err();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
